// File: rtl/sum_accumulator.sv
// sum_accumulator: accumulates a run of signed 8-bit adder results into a
// signed 8-bit total, with a sticky step-overflow flag and a saturating count
// of upstream overflow flags.
// Optional feature: define SUM_ACC_SAT_EN to clamp the total on step overflow
// (+127 / -128) instead of wrapping modulo 256.
module sum_accumulator #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       sum_in,
    input  logic             ovf_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       acc_out,
    output logic             acc_ovf,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] remaining;
    logic             launch;
    logic             accept;
    logic [7:0]       step_sum;
    logic             step_ovf;
    logic [7:0]       step_val;

    // in_ready is a registered copy of (state == ACCUM), so it gates acceptance
    assign launch = (state == IDLE) && start;
    assign accept = in_ready && in_valid;

    // Next-state decode; the last accepted sample goes straight to DONE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept && (remaining == CNT_W'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register plus registered status flags decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == ACCUM);
            out_valid <= (state_next == DONE);
            busy      <= (state_next != IDLE);
        end
    end

    // One accumulation step: signed add with same-sign-in/different-sign-out overflow
    always_comb begin
        step_sum = acc_out + sum_in;
        step_ovf = (acc_out[7] == sum_in[7]) && (step_sum[7] != acc_out[7]);
`ifdef SUM_ACC_SAT_EN
        if (step_ovf) begin
            step_val = acc_out[7] ? 8'h80 : 8'h7F;
        end else begin
            step_val = step_sum;
        end
`else
        step_val = step_sum;
`endif
    end

    // Run datapath: cleared on launch, updated per accepted sample, otherwise held
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_out   <= 8'h00;
            acc_ovf   <= 1'b0;
            ovf_cnt   <= '0;
            remaining <= '0;
        end else if (launch) begin
            acc_out   <= 8'h00;
            acc_ovf   <= 1'b0;
            ovf_cnt   <= '0;
            remaining <= len;
        end else if (accept) begin
            acc_out   <= step_val;
            remaining <= remaining - CNT_W'(1);
            if (step_ovf) begin
                acc_ovf <= 1'b1;
            end
            if (ovf_in && (ovf_cnt != '1)) begin
                ovf_cnt <= ovf_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator: directed vector table, hand-written
// reset / handshake sequences, and randomized runs against a numeric model.
module tb_sum_accumulator;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       sum_in;
    logic             ovf_in;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       acc_out;
    logic             acc_ovf;
    logic [CNT_W-1:0] ovf_cnt;
    logic             busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int               len;
        logic [15:0][7:0] smp;
        logic [15:0]      ov;
        int               gap;
        int               hold;
        int               exp_acc;
        int               exp_ovf;
        int               exp_cnt;
    } vec_t;

    sum_accumulator #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .ovf_in    (ovf_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .acc_ovf   (acc_ovf),
        .ovf_cnt   (ovf_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Numeric reference: integer sum per step, range check, then wrap or clamp
    task automatic model(input vec_t v, output int acc, output int ovf, output int cnt);
        int t;
        acc = 0; ovf = 0; cnt = 0;
        for (int i = 0; i < v.len; i++) begin
            t = acc + int'($signed(v.smp[i]));
            if (t > 127 || t < -128) begin
                ovf = 1;
`ifdef SUM_ACC_SAT_EN
                t = (t > 127) ? 127 : -128;
`else
                t = ((t + 384) % 256) - 128;
`endif
            end
            acc = t;
            if (v.ov[i] && cnt < (1 << CNT_W) - 1) cnt++;
        end
    endtask

    function automatic vec_t mk(input int n, input int s0, input int s1, input int s2,
                                input bit o0, input bit o1, input bit o2,
                                input int gap, input int hold,
                                input int ea, input int eo, input int ec);
        vec_t v;
        v.len = n; v.smp = '0; v.ov = '0;
        v.smp[0] = 8'(s0); v.smp[1] = 8'(s1); v.smp[2] = 8'(s2);
        v.ov[0] = o0; v.ov[1] = o1; v.ov[2] = o2;
        v.gap = gap; v.hold = hold;
        v.exp_acc = ea; v.exp_ovf = eo; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic wait_ready(input string nm);
        int k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk({nm, " in_ready timeout"}, 0, 1);
    endtask

    // Apply one run; inputs change and outputs are sampled on the falling edge
    task automatic run_vec(input string nm, input vec_t v);
        start = 1'b1; len = CNT_W'(v.len);
        @(negedge clk);
        start = 1'b0;
        chk({nm, " busy after start"}, int'(busy), 1);
        for (int i = 0; i < v.len; i++) begin
            for (int g = 0; g < v.gap; g++) begin
                // start pulses in ACCUM must not reload the run
                start = 1'b1; len = '1; in_valid = 1'b0;
                @(negedge clk);
                start = 1'b0;
            end
            wait_ready(nm);
            in_valid = 1'b1; sum_in = v.smp[i]; ovf_in = v.ov[i];
            @(negedge clk);
            in_valid = 1'b0; ovf_in = 1'b0;
        end
        chk({nm, " out_valid"}, int'(out_valid), 1);
        chk({nm, " in_ready low in DONE"}, int'(in_ready), 0);
        for (int h = 0; h < v.hold; h++) begin
            start = 1'b1; len = CNT_W'(1); in_valid = 1'b1; sum_in = 8'd99;
            @(negedge clk);
            start = 1'b0; in_valid = 1'b0;
            chk({nm, " out_valid held"}, int'(out_valid), 1);
        end
        chk({nm, " acc_out"}, int'($signed(acc_out)), v.exp_acc);
        chk({nm, " acc_ovf"}, int'(acc_ovf), v.exp_ovf);
        chk({nm, " ovf_cnt"}, int'(ovf_cnt), v.exp_cnt);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " idle after handshake"}, int'(busy), 0);
        chk({nm, " out_valid cleared"}, int'(out_valid), 0);
        chk({nm, " acc_out retained"}, int'($signed(acc_out)), v.exp_acc);
    endtask

    vec_t tbl[7];

    initial begin
        vec_t v;
        int ea, eo, ec;

        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; sum_in = '0;
        ovf_in = 1'b0; out_ready = 1'b0;

`ifdef SUM_ACC_SAT_EN
        tbl[1] = mk(2, 114, 20, 0, 0, 0, 0, 0, 0, 127, 1, 0);
        tbl[2] = mk(3, -126, -100, 126, 1, 0, 1, 0, 0, -2, 1, 2);
        tbl[6] = mk(2, -1, -128, 0, 0, 0, 0, 0, 0, -128, 1, 0);
`else
        tbl[1] = mk(2, 114, 20, 0, 0, 0, 0, 0, 0, -122, 1, 0);
        tbl[2] = mk(3, -126, -100, 126, 1, 0, 1, 0, 0, -100, 1, 2);
        tbl[6] = mk(2, -1, -128, 0, 0, 0, 0, 0, 0, 127, 1, 0);
`endif
        tbl[0] = mk(2, 64, 50, 0, 0, 0, 0, 0, 0, 114, 0, 0);
        tbl[3] = mk(3, 10, -20, 5, 0, 1, 0, 2, 5, -5, 0, 1);
        tbl[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        tbl[5] = mk(1, -128, 0, 0, 1, 0, 0, 0, 0, -128, 0, 1);

        repeat (2) @(negedge clk);
        chk("reset acc_out", int'(acc_out), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset in_ready", int'(in_ready), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset mid-run after the first of four samples
        start = 1'b1; len = CNT_W'(4);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; sum_in = 8'd40; ovf_in = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; ovf_in = 1'b0;
        chk("midrun partial acc", int'($signed(acc_out)), 40);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun rst busy", int'(busy), 0);
        chk("midrun rst acc_out", int'(acc_out), 0);
        chk("midrun rst ovf_cnt", int'(ovf_cnt), 0);
        chk("midrun rst in_ready", int'(in_ready), 0);
        chk("midrun rst out_valid", int'(out_valid), 0);
        run_vec("after rst", mk(1, 7, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0));

        // start together with out_ready in DONE only completes the handshake
        start = 1'b1; len = '0;
        @(negedge clk);
        start = 1'b0;
        chk("len0 done", int'(out_valid), 1);
        start = 1'b1; len = CNT_W'(2); out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b0;
        chk("start+out_ready busy", int'(busy), 0);
        @(negedge clk);
        chk("no new run", int'(busy), 0);

        // rst has priority over start
        rst = 1'b1; start = 1'b1; len = CNT_W'(3);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst over start", int'(busy), 0);

        // Randomized runs against the model
        for (int r = 0; r < 25; r++) begin
            v.len = int'($urandom_range(0, 6));
            v.smp = '0; v.ov = '0;
            for (int i = 0; i < 16; i++) begin
                v.smp[i] = 8'($urandom);
                v.ov[i]  = 1'($urandom);
            end
            v.gap  = int'($urandom_range(0, 2));
            v.hold = int'($urandom_range(0, 2));
            model(v, ea, eo, ec);
            v.exp_acc = ea; v.exp_ovf = eo; v.exp_cnt = ec;
            run_vec($sformatf("rand%0d", r), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
